// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter select encodings, the fetch FSM
// state encoding, and a helper that folds redirect selects onto the two
// legal targets.
package cpu_pkg;

    localparam logic [2:0] PC_SEL_INC = 3'b000;
    localparam logic [2:0] PC_SEL_IMM = 3'b001;
    localparam logic [2:0] PC_SEL_MEM = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ACK = 3'd2,
        FULL     = 3'd3,
        REDIR    = 3'd4
    } fetch_state_e;

    // Execute may only redirect to an immediate or a memory-address target;
    // anything other than the memory select falls back to the immediate.
    function automatic logic [2:0] norm_sel(input logic [2:0] sel);
        return (sel == PC_SEL_MEM) ? PC_SEL_MEM : PC_SEL_IMM;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory read channel plus the
// instruction hand-off to decode.
//   master (fetch unit): drives mem_rd/mem_addr, instr/instr_pc/instr_valid;
//                        samples mem_rdata/mem_ack, dec_ready.
//   slave  (memory + decode side): the mirror image.
interface instr_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               dec_ready;

    modport master (
        output mem_rd, mem_addr, instr, instr_pc, instr_valid,
        input  mem_rdata, mem_ack, dec_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid,
        output mem_rdata, mem_ack, dec_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Reads one word at the current pc, holds it for
// decode, then steps the external program counter. Branch/jump redirects from
// execute are parked in a pending register and applied from the REDIR state;
// a read already issued when a redirect arrives is allowed to complete and
// its data is dropped.
// Ports:
//   clk, rst           clock, async active-low reset
//   pc                 current program counter value
//   pc_en/pc_sel/pc_imm/pc_mem_addr   program-counter update request
//   redirect/redirect_sel/redirect_imm/redirect_addr   one-cycle redirect
//   bus                memory read channel + decode hand-off (master side)
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic [2:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_imm,
    output logic [ADDR_W-1:0] pc_mem_addr,
    input  logic              redirect,
    input  logic [2:0]        redirect_sel,
    input  logic [ADDR_W-1:0] redirect_imm,
    input  logic [ADDR_W-1:0] redirect_addr,
    instr_fetch_if.master     bus
);

    fetch_state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               instr_valid_q;
    logic               first_q;     // first cycle in FULL: issue the increment
    logic               discard_q;   // outstanding read belongs to a dead path
    logic [2:0]         pend_sel_q;
    logic [ADDR_W-1:0]  pend_imm_q;
    logic [ADDR_W-1:0]  pend_addr_q;

    logic mem_rd;
    logic take_ack;
    logic clr_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_rd      = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PC_SEL_INC;
        pc_imm      = '0;
        pc_mem_addr = '0;
        take_ack    = 1'b0;
        clr_valid   = 1'b0;
        case (state_q)
            IDLE: state_d = redirect ? REDIR : FETCH;
            FETCH: begin
                mem_rd  = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    // A redirect in the ack cycle kills this word just like
                    // one seen earlier in the read.
                    if (discard_q || redirect) begin
                        state_d = REDIR;
                    end else begin
                        state_d  = FULL;
                        take_ack = 1'b1;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    // Redirect wins: no increment, word is flushed.
                    state_d   = REDIR;
                    clr_valid = 1'b1;
                end else begin
                    pc_en = first_q;
                    if (instr_valid_q && bus.dec_ready) begin
                        state_d   = FETCH;
                        clr_valid = 1'b1;
                    end
                end
            end
            REDIR: begin
                pc_en       = 1'b1;
                pc_sel      = pend_sel_q;
                pc_imm      = pend_imm_q;
                pc_mem_addr = pend_addr_q;
                // A newer redirect re-targets; stay here to apply it next.
                state_d     = redirect ? REDIR : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            first_q       <= 1'b0;
            discard_q     <= 1'b0;
            pend_sel_q    <= PC_SEL_INC;
            pend_imm_q    <= '0;
            pend_addr_q   <= '0;
        end else begin
            first_q <= take_ack;
            if (take_ack) begin
                instr_q       <= bus.mem_rdata;
                instr_pc_q    <= pc;
                instr_valid_q <= 1'b1;
            end else if (clr_valid) begin
                instr_valid_q <= 1'b0;
            end
            if (redirect) begin
                pend_sel_q  <= norm_sel(redirect_sel);
                pend_imm_q  <= redirect_imm;
                pend_addr_q <= redirect_addr;
            end
            if (state_q == WAIT_ACK && bus.mem_ack)
                discard_q <= 1'b0;
            else if (redirect && (state_q == FETCH || state_q == WAIT_ACK))
                discard_q <= 1'b1;
        end
    end

    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = mem_rd ? pc : '0;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The bench plays the program counter and
// the instruction memory (word at address a is {~a[7:0], a[7:0]}).
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int AW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_init = '0;
    logic          pc_en;
    logic [2:0]    pc_sel;
    logic [AW-1:0] pc_imm, pc_mem_addr;
    logic          redirect = 1'b0;
    logic [2:0]    redirect_sel = 3'b000;
    logic [AW-1:0] redirect_imm = '0, redirect_addr = '0;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus();

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .pc_en(pc_en), .pc_sel(pc_sel), .pc_imm(pc_imm), .pc_mem_addr(pc_mem_addr),
        .redirect(redirect), .redirect_sel(redirect_sel),
        .redirect_imm(redirect_imm), .redirect_addr(redirect_addr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Program counter beside the fetch unit.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= pc_init;
        else if (pc_en) begin
            case (pc_sel)
                3'b000:  pc <= pc + 16'd1;
                3'b001:  pc <= pc_imm;
                3'b010:  pc <= pc_mem_addr;
                default: pc <= pc;
            endcase
        end
    end

    // Edge monitor: increments issued, handshakes taken, stale data seen.
    int            n_inc = 0;
    int            hs_n  = 0;
    logic [AW-1:0] hs_pc [0:31];
    logic [IW-1:0] hs_in [0:31];
    logic          saw_bad = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            if (pc_en && pc_sel == 3'b000) n_inc <= n_inc + 1;
            if (bus.instr_valid && bus.dec_ready && hs_n < 32) begin
                hs_pc[hs_n] <= bus.instr_pc;
                hs_in[hs_n] <= bus.instr;
                hs_n        <= hs_n + 1;
            end
            if (bus.instr_valid && bus.instr == 16'h1234) saw_bad <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] dfn(input logic [AW-1:0] a);
        return {~a[7:0], a[7:0]};
    endfunction

    // Memory responder: ack in the second cycle of every read.
    logic auto_ack = 1'b1;
    logic rd_seen  = 1'b0;
    logic          ovr_en = 1'b0;
    logic [IW-1:0] ovr_data = '0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            bus.mem_ack   = bus.mem_rd && rd_seen;
            bus.mem_rdata = ovr_en ? ovr_data : dfn(bus.mem_addr);
        end
        rd_seen = bus.mem_rd && !bus.mem_ack;
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int k = 0;
        while (!bus.instr_valid && k < lim) begin
            cyc();
            k++;
        end
        chk(tag, {31'd0, bus.instr_valid}, 32'd1);
    endtask

    int inc0, hs0, k;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.dec_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_pc_sel", {29'd0, pc_sel}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("rst_instr_pc", {16'd0, bus.instr_pc}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);

        // Sequential fetch 0,1,2 with immediate acks
        @(posedge clk); #1;
        rst = 1'b1;
        inc0 = n_inc;
        hs0  = hs_n;
        cyc();
        chk("seq_fetch_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("seq_fetch_addr", {16'd0, bus.mem_addr}, 32'h0000);
        cyc();
        chk("seq_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("seq_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        cyc();
        chk("seq_lat_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("seq_instr0", {16'd0, bus.instr}, 32'h0000FF00);
        chk("seq_pc_en", {31'd0, pc_en}, 32'd1);
        chk("seq_pc_sel", {29'd0, pc_sel}, 32'd0);
        k = 0;
        while (hs_n - hs0 < 3 && k < 30) begin
            cyc();
            k++;
        end
        chk("seq_hs_count", hs_n - hs0, 32'd3);
        chk("seq_pc0", {16'd0, hs_pc[hs0]}, 32'h0000);
        chk("seq_pc1", {16'd0, hs_pc[hs0+1]}, 32'h0001);
        chk("seq_pc2", {16'd0, hs_pc[hs0+2]}, 32'h0002);
        chk("seq_in2", {16'd0, hs_in[hs0+2]}, 32'h0000FD02);
        chk("seq_inc_count", n_inc - inc0, 32'd3);

        // Decode stall holds the word, no re-read, single increment
        bus.dec_ready = 1'b0;
        ovr_en   = 1'b1;
        ovr_data = 16'hA5A5;
        inc0 = n_inc;
        wait_valid("stall_valid", 10);
        chk("stall_pc", {16'd0, bus.instr_pc}, 32'h0003);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_instr", {16'd0, bus.instr}, 32'h0000A5A5);
            chk("stall_vld", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_no_rd", {31'd0, bus.mem_rd}, 32'd0);
        end
        chk("stall_inc_once", n_inc - inc0, 32'd1);
        bus.dec_ready = 1'b1;
        ovr_en   = 1'b0;
        auto_ack = 1'b0;
        bus.mem_ack = 1'b0;
        cyc();
        chk("stall_release_vld", {31'd0, bus.instr_valid}, 32'd0);
        chk("stall_next_addr", {16'd0, bus.mem_addr}, 32'h0004);

        // Redirect during WAIT_ACK, late ack with stale data
        cyc();
        chk("rw_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
        redirect = 1'b1; redirect_sel = 3'b001;
        redirect_imm = 16'h0040; redirect_addr = 16'h0999;
        cyc();
        redirect = 1'b0;
        chk("rw_read_kept", {31'd0, bus.mem_rd}, 32'd1);
        chk("rw_no_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        cyc();
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
        cyc();
        bus.mem_ack = 1'b0;
        chk("rw_redir_vld", {31'd0, bus.instr_valid}, 32'd0);
        chk("rw_redir_en", {31'd0, pc_en}, 32'd1);
        chk("rw_redir_sel", {29'd0, pc_sel}, 32'd1);
        chk("rw_redir_imm", {16'd0, pc_imm}, 32'h0040);
        cyc();
        chk("rw_new_addr", {16'd0, bus.mem_addr}, 32'h0040);
        chk("rw_stale_dropped", {31'd0, saw_bad}, 32'd0);

        // Redirect coincident with handshake in first FULL cycle
        auto_ack = 1'b1;
        cyc();
        cyc();
        chk("rf_full_vld", {31'd0, bus.instr_valid}, 32'd1);
        chk("rf_full_instr", {16'd0, bus.instr}, 32'h0000BF40);
        inc0 = n_inc;
        redirect = 1'b1; redirect_sel = 3'b010;
        redirect_imm = 16'h0077; redirect_addr = 16'h0100;
        #1;
        chk("rf_suppress_en", {31'd0, pc_en}, 32'd0);
        cyc();
        redirect = 1'b0;
        chk("rf_redir_en", {31'd0, pc_en}, 32'd1);
        chk("rf_redir_sel", {29'd0, pc_sel}, 32'd2);
        chk("rf_redir_addr", {16'd0, pc_mem_addr}, 32'h0100);
        chk("rf_flushed", {31'd0, bus.instr_valid}, 32'd0);
        chk("rf_no_inc", n_inc - inc0, 32'd0);
        cyc();
        chk("rf_new_addr", {16'd0, bus.mem_addr}, 32'h0100);

        // Wrap at the top of the address space
        pc_init = 16'hFFFF;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        rd_seen = 1'b0;
        bus.mem_ack = 1'b0;
        cyc();
        chk("wrap_addr", {16'd0, bus.mem_addr}, 32'h0000FFFF);
        cyc();
        cyc();
        chk("wrap_instr_pc", {16'd0, bus.instr_pc}, 32'h0000FFFF);
        chk("wrap_instr", {16'd0, bus.instr}, 32'h000000FF);
        cyc();
        chk("wrap_next_addr", {16'd0, bus.mem_addr}, 32'h0000);
        chk("wrap_next_rd", {31'd0, bus.mem_rd}, 32'd1);

        // Reset in the middle of a read
        auto_ack = 1'b0;
        bus.mem_ack = 1'b0;
        cyc();
        chk("mid_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
        pc_init = 16'h0000;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("mid_rst_en", {31'd0, pc_en}, 32'd0);
        chk("mid_rst_vld", {31'd0, bus.instr_valid}, 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        cyc();
        cyc();
        chk("mid_ack_ignored", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_hold_rd", {31'd0, bus.mem_rd}, 32'd0);
        rst = 1'b1;
        cyc();
        chk("mid_restart_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("mid_restart_addr", {16'd0, bus.mem_addr}, 32'h0000);
        chk("mid_first_ack_ign", {31'd0, bus.instr_valid}, 32'd0);
        bus.mem_ack = 1'b0;
        auto_ack = 1'b1;
        rd_seen = 1'b1;
        wait_valid("mid_refetch_vld", 10);
        chk("mid_refetch_instr", {16'd0, bus.instr}, 32'h0000FF00);
        chk("mid_refetch_pc", {16'd0, bus.instr_pc}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
